// File: rtl/vga_pkg.sv
// Default 640x480@60 VGA timing constants, sync polarities and a helper
// that sizes the scan counters from the frame totals.
package vga_pkg;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  localparam int unsigned VGA_CLK_DIV = 4;

  // Bits needed to hold max(h_total, v_total) - 1.
  function automatic int unsigned count_width(input int unsigned h_total,
                                              input int unsigned v_total);
    int unsigned max_total;
    max_total = (h_total > v_total) ? h_total : v_total;
    return (max_total > 1) ? $clog2(max_total) : 1;
  endfunction

  localparam int unsigned VGA_CW = count_width(VGA_H_TOTAL, VGA_V_TOTAL);

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: registered one-clk tick every DIV enabled clocks.
// Holds its phase while en is low so a resumed run loses no period.
module clk_en_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    tick_d    = tick_q;
    if (en) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
      tick_d    = (div_cnt_d == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q & en;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: owns the scan counters and registers
// sync, blanking, coordinates and line/frame pulses with zero skew.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter logic        H_POL     = SYNC_ACTIVE_LOW,
  parameter logic        V_POL     = SYNC_ACTIVE_LOW,
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned CW        = VGA_CW,
  parameter int unsigned FC_W      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic            pix_tick,
  output logic [CW-1:0]   h_count,
  output logic [CW-1:0]   v_count,
  output logic [CW-1:0]   x_loc,
  output logic [CW-1:0]   y_loc,
  output logic            video_on,
  output logic            h_sync,
  output logic            v_sync,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Window bounds carry one extra bit so an end bound equal to 2**CW still fits.
  localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_DISPLAY);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_DISPLAY + H_FRONT);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_DISPLAY);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_DISPLAY + V_FRONT);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_DISPLAY + V_FRONT + V_SYNC);

  logic            tick;
  logic [CW-1:0]   h_count_q, h_count_d;
  logic [CW-1:0]   v_count_q, v_count_d;
  logic [CW-1:0]   x_loc_q, x_loc_d;
  logic [CW-1:0]   y_loc_q, y_loc_d;
  logic            video_on_q, video_on_d;
  logic            h_sync_q, h_sync_d;
  logic            v_sync_q, v_sync_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic [FC_W-1:0] frame_count_q, frame_count_d;
  logic            h_active, v_active, h_in_sync, v_in_sync;

  clk_en_div #(
    .DIV(CLK_DIV)
  ) u_pix_div (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_count_d = frame_count_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (tick) begin
      if (h_count_q == H_LAST) begin
        h_count_d    = '0;
        line_start_d = 1'b1;
        if (v_count_q == V_LAST) begin
          v_count_d     = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 1'b1;
        end else begin
          v_count_d = v_count_q + 1'b1;
        end
      end else begin
        h_count_d = h_count_q + 1'b1;
      end
    end

    // Decode the next counter values so the registered outputs line up with them.
    h_active   = {1'b0, h_count_d} < H_ACT_END;
    v_active   = {1'b0, v_count_d} < V_ACT_END;
    h_in_sync  = ({1'b0, h_count_d} >= H_SYNC_BEG) && ({1'b0, h_count_d} < H_SYNC_END);
    v_in_sync  = ({1'b0, v_count_d} >= V_SYNC_BEG) && ({1'b0, v_count_d} < V_SYNC_END);
    video_on_d = h_active && v_active;
    x_loc_d    = video_on_d ? h_count_d : '0;
    y_loc_d    = video_on_d ? v_count_d : '0;
    h_sync_d   = h_in_sync ? H_POL : ~H_POL;
    v_sync_d   = v_in_sync ? V_POL : ~V_POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      x_loc_q       <= '0;
      y_loc_q       <= '0;
      video_on_q    <= 1'b1;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      x_loc_q       <= x_loc_d;
      y_loc_q       <= y_loc_d;
      video_on_q    <= video_on_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pix_tick    = tick;
  assign h_count     = h_count_q;
  assign v_count     = v_count_q;
  assign x_loc       = x_loc_q;
  assign y_loc       = y_loc_q;
  assign video_on    = video_on_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign line_start  = line_start_q & en;
  assign frame_start = frame_start_q & en;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against
// an arithmetic scan model, plus literal pins on timing landmarks.
module tb_vga_timing_gen;

  typedef struct packed {
    int unsigned hd, hf, hs, hb, vd, vf, vs, vb, div, fcmod;
    logic hpol, vpol;
  } cfg_t;

  typedef struct packed {
    int unsigned div, h, v, fc;
    logic tick, ls, fs;
  } st_t;

  typedef struct packed {
    logic tick, von, hs, vs, ls, fs;
    logic [31:0] h, v, x, y, fc;
  } obs_t;

  localparam cfg_t CFG_0 = '{hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33,
                             div:4, fcmod:256, hpol:1'b0, vpol:1'b0};
  localparam cfg_t CFG_A = '{hd:8, hf:2, hs:3, hb:2, vd:6, vf:1, vs:2, vb:1,
                             div:3, fcmod:8, hpol:1'b0, vpol:1'b0};
  localparam cfg_t CFG_B = '{hd:10, hf:3, hs:4, hb:3, vd:7, vf:2, vs:3, vb:2,
                             div:1, fcmod:16, hpol:1'b1, vpol:1'b1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_0 = 1'b1, en_a = 1'b1, en_b = 1'b1;
  logic chk_on = 1'b0;
  int unsigned errors = 0, checks = 0;

  logic       pt_0, von_0, hs_0, vs_0, ls_0, fs_0;
  logic [9:0] hc_0, vc_0, x_0, y_0;
  logic [7:0] fc_0;
  logic       pt_a, von_a, hs_a, vs_a, ls_a, fs_a;
  logic [3:0] hc_a, vc_a, x_a, y_a;
  logic [2:0] fc_a;
  logic       pt_b, von_b, hs_b, vs_b, ls_b, fs_b;
  logic [4:0] hc_b, vc_b, x_b, y_b;
  logic [3:0] fc_b;

  st_t m0 = '0, ma = '0, mb = '0;

  always #5 clk = ~clk;

  vga_timing_gen dut_0 (
    .clk(clk), .reset(reset), .en(en_0), .pix_tick(pt_0), .h_count(hc_0), .v_count(vc_0),
    .x_loc(x_0), .y_loc(y_0), .video_on(von_0), .h_sync(hs_0), .v_sync(vs_0),
    .line_start(ls_0), .frame_start(fs_0), .frame_count(fc_0)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(3), .CW(4), .FC_W(3)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .pix_tick(pt_a), .h_count(hc_a), .v_count(vc_a),
    .x_loc(x_a), .y_loc(y_a), .video_on(von_a), .h_sync(hs_a), .v_sync(vs_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(10), .H_FRONT(3), .H_SYNC(4), .H_BACK(3),
    .V_DISPLAY(7), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
    .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CW(5), .FC_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .pix_tick(pt_b), .h_count(hc_b), .v_count(vc_b),
    .x_loc(x_b), .y_loc(y_b), .video_on(von_b), .h_sync(hs_b), .v_sync(vs_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  // One clock edge of the scan: divider phase, then pixel/line/frame positions modulo totals.
  function automatic st_t step(st_t s, cfg_t c, logic rst, logic en);
    st_t n;
    int unsigned ht, vt;
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    if (rst) return '0;
    n = s;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (!en) return n;
    n.div  = (s.div + 1) % c.div;
    n.tick = (n.div == c.div - 1);
    if (s.tick) begin
      n.h = (s.h + 1) % ht;
      if (n.h == 0) begin
        n.ls = 1'b1;
        n.v  = (s.v + 1) % vt;
        if (n.v == 0) begin
          n.fs = 1'b1;
          n.fc = (s.fc + 1) % c.fcmod;
        end
      end
    end
    return n;
  endfunction

  function automatic obs_t exp_obs(st_t s, cfg_t c, logic en);
    obs_t o;
    logic act;
    act    = (s.h < c.hd) && (s.v < c.vd);
    o.tick = en && s.tick;
    o.ls   = en && s.ls;
    o.fs   = en && s.fs;
    o.von  = act;
    o.h    = s.h;
    o.v    = s.v;
    o.x    = act ? s.h : 0;
    o.y    = act ? s.v : 0;
    o.fc   = s.fc;
    o.hs   = (s.h >= c.hd + c.hf && s.h < c.hd + c.hf + c.hs) ? c.hpol : ~c.hpol;
    o.vs   = (s.v >= c.vd + c.vf && s.v < c.vd + c.vf + c.vs) ? c.vpol : ~c.vpol;
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t g, input obs_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s t=%0t got tick=%0b h=%0d v=%0d x=%0d y=%0d von=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d expected tick=%0b h=%0d v=%0d x=%0d y=%0d von=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
               nm, $time, g.tick, g.h, g.v, g.x, g.y, g.von, g.hs, g.vs, g.ls, g.fs, g.fc,
               e.tick, e.h, e.v, e.x, e.y, e.von, e.hs, e.vs, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic chk(input string nm, input int unsigned got, input int unsigned want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, want);
    end
  endtask

  always @(posedge clk) begin
    m0 = step(m0, CFG_0, reset, en_0);
    ma = step(ma, CFG_A, reset, en_a);
    mb = step(mb, CFG_B, reset, en_b);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_0", '{tick:pt_0, von:von_0, hs:hs_0, vs:vs_0, ls:ls_0, fs:fs_0, h:32'(hc_0),
                       v:32'(vc_0), x:32'(x_0), y:32'(y_0), fc:32'(fc_0)}, exp_obs(m0, CFG_0, en_0));
      cmp("model_a", '{tick:pt_a, von:von_a, hs:hs_a, vs:vs_a, ls:ls_a, fs:fs_a, h:32'(hc_a),
                       v:32'(vc_a), x:32'(x_a), y:32'(y_a), fc:32'(fc_a)}, exp_obs(ma, CFG_A, en_a));
      cmp("model_b", '{tick:pt_b, von:von_b, hs:hs_b, vs:vs_b, ls:ls_b, fs:fs_b, h:32'(hc_b),
                       v:32'(vc_b), x:32'(x_b), y:32'(y_b), fc:32'(fc_b)}, exp_obs(mb, CFG_B, en_b));
    end
  end

  initial begin
    int unsigned n, hs_ticks, hs_min, hs_max, voff_h, ls_cnt, ls_v, ls_h, bad, pulses;
    int unsigned ticks, hs_hi, vs_hi, vs_min, vs_max, fc_first;
    logic [2:0] prev_fc;
    logic seen_wrap;

    @(posedge clk); #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Default timing: tick lands in every 4th clock after reset.
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("tick_clk%0d", k), pt_0, (k % 4 == 0) ? 1 : 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("h_after_12", hc_0, 3);
    chk("hsync_idle", hs_0, 1);
    chk("vsync_idle", vs_0, 1);
    chk("von_start", von_0, 1);

    // Scan line 0 fully and into line 1 up to h=99.
    n = 0; hs_ticks = 0; hs_min = 9999; hs_max = 0; voff_h = 9999; ls_cnt = 0; ls_v = 99; ls_h = 99;
    while (n < 8000) begin
      @(negedge clk);
      n++;
      if (pt_0 && !hs_0) begin
        hs_ticks++;
        if (hc_0 < hs_min) hs_min = hc_0;
        if (hc_0 > hs_max) hs_max = hc_0;
      end
      if (!von_0 && vc_0 == 0 && hc_0 < voff_h) voff_h = hc_0;
      if (ls_0) begin ls_cnt++; ls_v = vc_0; ls_h = hc_0; end
      if (pt_0 && hc_0 == 99 && vc_0 == 1) break;
    end
    chk("line_scan_bound", (n < 8000) ? 1 : 0, 1);
    chk("hsync_ticks", hs_ticks, 96);
    chk("hsync_first", hs_min, 656);
    chk("hsync_last", hs_max, 751);
    chk("von_fall_h", voff_h, 640);
    chk("line_start_cnt", ls_cnt, 1);
    chk("line_start_v", ls_v, 1);
    chk("line_start_h", ls_h, 0);

    // Freeze right after the edge that makes h=100.
    @(posedge clk); #1 en_0 = 1'b0;
    bad = 0; pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (hc_0 != 100 || vc_0 != 1 || fc_0 != 0) bad++;
      if (pt_0 || ls_0 || fs_0) pulses++;
      @(posedge clk); #1;
    end
    chk("frozen_counters", bad, 0);
    chk("frozen_pulses", pulses, 0);
    en_0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("resume_h_3clk", hc_0, 100);
    @(posedge clk);
    @(negedge clk);
    chk("resume_h_4clk", hc_0, 101);

    // Random enables with occasional resets.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      en_a  = ($urandom_range(0, 99) < 75);
      en_0  = ($urandom_range(0, 99) < 90);
      reset = ($urandom_range(0, 799) == 0);
    end
    @(posedge clk); #1 reset = 1'b0; en_a = 1'b1; en_0 = 1'b1;

    // Mid-frame reset on config A with en held high.
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (hc_a == 7 && vc_a == 5) break;
    end
    chk("a_reach_bound", (n < 2000) ? 1 : 0, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_h", hc_a, 0);
    chk("rst_v", vc_a, 0);
    chk("rst_x", x_a, 0);
    chk("rst_y", y_a, 0);
    chk("rst_von", von_a, 1);
    chk("rst_hs", hs_a, 1);
    chk("rst_vs", vs_a, 1);
    chk("rst_tick", pt_a, 0);
    chk("rst_pulses", {ls_a, fs_a}, 0);
    chk("rst_fc", fc_a, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("restart_h", hc_a, 1);
    chk("restart_v", vc_a, 0);

    // Long run without resets so the 3-bit frame counter wraps.
    seen_wrap = 1'b0;
    prev_fc = fc_a;
    for (int i = 0; i < 7000; i++) begin
      @(posedge clk); #1 en_a = ($urandom_range(0, 99) < 75);
      @(negedge clk);
      if (prev_fc == 3'd7 && fc_a == 3'd0) seen_wrap = 1'b1;
      prev_fc = fc_a;
    end
    chk("fc_wrap_seen", seen_wrap, 1);
    @(posedge clk); #1 en_a = 1'b1;

    // Config B: one frame at one pixel per clock.
    n = 0;
    while (n < 1000 && !fs_b) begin @(negedge clk); n++; end
    chk("b_fs_bound", (n < 1000) ? 1 : 0, 1);
    fc_first = fc_b;
    n = 0; ticks = 0; hs_hi = 0; vs_hi = 0; vs_min = 99; vs_max = 0;
    do begin
      if (pt_b) ticks++;
      if (hs_b) hs_hi++;
      if (vs_b) begin
        vs_hi++;
        if (vc_b < vs_min) vs_min = vc_b;
        if (vc_b > vs_max) vs_max = vc_b;
      end
      @(negedge clk);
      n++;
    end while (n < 1000 && !fs_b);
    chk("b_frame_clks", n, 280);
    chk("b_ticks", ticks, 280);
    chk("b_hsync_hi", hs_hi, 56);
    chk("b_vsync_hi", vs_hi, 60);
    chk("b_vsync_first", vs_min, 9);
    chk("b_vsync_last", vs_max, 11);
    chk("b_fc_inc", fc_b, (fc_first + 1) % 16);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Self-contained, parametrised VGA timing generator that owns its own horizontal and vertical scan counters. A synchronous pixel-enable divider runs them from the system clock. It produces registered sync, blanking, pixel coordinates and frame/line event pulses for the renderer and game logic. It replaces the externally-counted combinational sync decoder and adds:
- configurable resolution and porches
- sync polarity
- pause enable
- a frame counter for animation timing

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
H_POL, 0, h_sync active level (0 = active-low)
V_POL, 0, v_sync active level (0 = active-low)
CLK_DIV, 4, system clocks per pixel (>=1); 4 gives 25 MHz from 100 MHz
CW, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
FC_W, 8, frame counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  run enable; low freezes divider, counters and pulses
pix_tick  out  1  one-clk pulse per pixel period
h_count  out  CW  horizontal scan position, 0..H_TOTAL-1
v_count  out  CW  vertical scan position, 0..V_TOTAL-1
x_loc  out  CW  pixel x; equals h_count in active area, 0 otherwise
y_loc  out  CW  pixel y; equals v_count in active area, 0 otherwise
video_on  out  1  high in active area
h_sync  out  1  horizontal sync, level set by H_POL
v_sync  out  1  vertical sync, level set by V_POL
line_start  out  1  one-clk pulse when h_count wraps to 0
frame_start  out  1  one-clk pulse when (h_count,v_count) wraps to (0,0)
frame_count  out  FC_W  completed-frame counter, wraps modulo 2^FC_W

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1.
  - pix_tick is registered; it is high for the single clk in which div_cnt==CLK_DIV-1 (every 4th clk by default).
  - With CLK_DIV=1, pix_tick is high every enabled clk.
- Counters advance only on clk edges where pix_tick=1 and en=1.
  - h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments.
  - When both are at their terminal values, both wrap to 0.
- Decoded outputs (video_on, h_sync, v_sync, x_loc, y_loc) are registers loaded from the decode of the next counter values. They are therefore always consistent with h_count/v_count in the same cycle (zero skew).
- Decode rules:
  - video_on = h<H_DISPLAY && v<V_DISPLAY.
  - h_sync is active for H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - v_sync is active for lines 490..491.
  - Outside those windows, syncs are at the inactive level (~H_POL, ~V_POL).
- line_start and frame_start are asserted in the clk after the advancing edge that produces the wrap. They coincide with the new counter value and last exactly one clk.
- frame_count increments on the same edge that produces frame_start; it wraps from 2^FC_W-1 to 0.
- en=0: all registers hold. pix_tick, line_start and frame_start are forced to 0. Resuming continues from the held state with no lost or extra pixel.
- Reset values (also applied on reset mid-frame, next clk):
  - div_cnt=0, h_count=0, v_count=0, frame_count=0
  - pix_tick=0, line_start=0, frame_start=0
  - x_loc=0, y_loc=0, video_on=1 (decode of 0,0)
  - h_sync=~H_POL, v_sync=~V_POL
- Reset dominates en.
- Arithmetic: all comparisons are unsigned at width CW; no counter ever exceeds its TOTAL-1.

Decomposition:
- Package vga_pkg:
  - default 640x480@60 timing constants and derived H_TOTAL/V_TOTAL
  - sync-polarity constants
  - a function computing the required CW from the totals
- Sub-module clk_en_div (parameter DIV): divider plus registered pix_tick with en input; reusable by the game tick logic.

Test Plan:
- Reset, then run 12 clks with en=1, CLK_DIV=4 -> pix_tick high on clks 4, 8, 12 only; h_count reaches 3; h_sync=1, v_sync=1, video_on=1.
- Run one full line -> h_sync low for exactly 96 pixel ticks (h_count 656..751); video_on low from h=640; line_start pulses once as h wraps 799->0 with v=1.
- Run to v=524, h=799 and advance one tick -> counters become (0,0), frame_start=1 for one clk, frame_count 0->1; v_sync was low only on lines 490 and 491.
- Drop en for 50 clks at h=100 -> counters, syncs and frame_count frozen, no pulses; re-raise en -> h=101 after exactly CLK_DIV clks.
- Assert reset at (h=300, v=200) -> next clk all outputs equal the reset values above; counting restarts from (0,0).
- Elaborate with H_POL=1, V_POL=1, CLK_DIV=1 -> pix_tick constantly 1; h_sync high only for h 656..751; one full frame takes exactly 420000 clks.
